// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one-outstanding-request fetcher with redirect, memory-init hold and accept counter.
// Optional macro IFU_TIMEOUT_EN adds a WAIT-state watchdog that raises the sticky fetch_fault.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC       = 64'h0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        meminit,
    input  logic        pc_load,
    input  logic [63:0] nextpc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [63:0] instruction,
    output logic [10:0] instr_31_21,
    output logic [4:0]  instr_20_16,
    output logic [4:0]  instr_9_5,
    output logic [4:0]  instr_4_0,
    output logic [63:0] programcounter,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] fetch_count,
    output logic        fetch_fault
);
    // state | meaning
    // IDLE  | no request; leaves once reset/meminit has settled for a cycle
    // WAIT  | imem_req high at imem_addr, waiting for imem_ack
    // HOLD  | instruction presented, waiting for the CPU to accept
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state;
    logic [63:0] pc_reg;
    logic        started;
    logic        unused_nextpc_lsb;

    assign unused_nextpc_lsb = ^nextpc[1:0];

    assign instr_31_21 = instruction[31:21];
    assign instr_20_16 = instruction[20:16];
    assign instr_9_5   = instruction[9:5];
    assign instr_4_0   = instruction[4:0];

`ifdef IFU_TIMEOUT_EN
    localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
`else
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pc_reg         <= RESET_PC;
            started        <= 1'b0;
            imem_req       <= 1'b0;
            imem_addr      <= 64'h0;
            instruction    <= 64'h0;
            programcounter <= 64'h0;
            instr_valid    <= 1'b0;
            fetch_count    <= 32'h0;
`ifdef IFU_TIMEOUT_EN
            wait_cnt       <= 8'h0;
            fetch_fault    <= 1'b0;
`endif
        end else if (meminit) begin
            state       <= IDLE;
            pc_reg      <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            started <= 1'b1;
            if (pc_load) begin
                // redirect wins over ack/ready: any data arriving this cycle is dropped
                state       <= IDLE;
                pc_reg      <= {nextpc[63:2], 2'b00};
                imem_req    <= 1'b0;
                instr_valid <= 1'b0;
`ifdef IFU_TIMEOUT_EN
                fetch_fault <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
`ifdef IFU_TIMEOUT_EN
                        if (started && !fetch_fault) begin
                            wait_cnt <= WAIT_LOAD;
`else
                        if (started) begin
`endif
                            state     <= WAIT;
                            imem_req  <= 1'b1;
                            imem_addr <= pc_reg;
                        end
                    end
                    WAIT: begin
                        if (imem_ack) begin
                            state          <= HOLD;
                            imem_req       <= 1'b0;
                            instruction    <= {32'h0, imem_rdata};
                            programcounter <= pc_reg;
                            pc_reg         <= pc_reg + 64'd4;
                            instr_valid    <= 1'b1;
                        end
`ifdef IFU_TIMEOUT_EN
                        else if (wait_cnt == 8'h0) begin
                            state       <= IDLE;
                            imem_req    <= 1'b0;
                            fetch_fault <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt - 8'd1;
                        end
`endif
                    end
                    HOLD: begin
                        if (instr_ready) begin
                            state       <= WAIT;
                            instr_valid <= 1'b0;
                            fetch_count <= fetch_count + 32'd1;
                            imem_req    <= 1'b1;
                            imem_addr   <= pc_reg;
`ifdef IFU_TIMEOUT_EN
                            wait_cnt    <= WAIT_LOAD;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle comparison against a transaction-level model plus literal pins.
module tb_instr_fetch_unit;
    localparam logic [63:0] RST_PC = 64'h0;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        meminit, pc_load, imem_ack, instr_ready;
    logic [63:0] nextpc;
    logic [31:0] imem_rdata;
    logic        imem_req, instr_valid, fetch_fault;
    logic [63:0] imem_addr, instruction, programcounter;
    logic [10:0] instr_31_21;
    logic [4:0]  instr_20_16, instr_9_5, instr_4_0;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(255)) dut (
        .clock(clock), .reset_n(reset_n), .meminit(meminit), .pc_load(pc_load),
        .nextpc(nextpc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
        .instr_31_21(instr_31_21), .instr_20_16(instr_20_16), .instr_9_5(instr_9_5),
        .instr_4_0(instr_4_0), .programcounter(programcounter),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .fetch_count(fetch_count), .fetch_fault(fetch_fault)
    );

    always #5 clock = ~clock;

    // Transaction-level model: a request is either pending, presented, or neither.
    logic        m_req = 0, m_valid = 0, m_started = 0;
    logic [63:0] m_pc = RST_PC, m_addr = 0, m_progc = 0;
    logic [31:0] m_word = 0, m_count = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_req = 0; m_valid = 0; m_started = 0; m_pc = RST_PC;
            m_addr = 0; m_progc = 0; m_word = 0; m_count = 0;
        end else if (meminit) begin
            m_pc = RST_PC; m_valid = 0; m_req = 0;
        end else begin
            if (pc_load) begin
                m_pc = nextpc & ~64'h3; m_valid = 0; m_req = 0;
            end else if (m_req && imem_ack) begin
                m_word = imem_rdata; m_progc = m_pc; m_pc = m_pc + 4;
                m_valid = 1; m_req = 0;
            end else if (m_valid && instr_ready) begin
                m_valid = 0; m_count = m_count + 1; m_req = 1; m_addr = m_pc;
            end else if (!m_req && !m_valid && m_started) begin
                m_req = 1; m_addr = m_pc;
            end
            m_started = 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("req", {63'b0, imem_req}, {63'b0, m_req});
        if (m_req) chk("addr", imem_addr, m_addr);
        chk("valid", {63'b0, instr_valid}, {63'b0, m_valid});
        chk("instruction", instruction, {32'h0, m_word});
        chk("f31_21", {53'b0, instr_31_21}, {53'b0, m_word[31:21]});
        chk("f20_16", {59'b0, instr_20_16}, {59'b0, m_word[20:16]});
        chk("f9_5", {59'b0, instr_9_5}, {59'b0, m_word[9:5]});
        chk("f4_0", {59'b0, instr_4_0}, {59'b0, m_word[4:0]});
        chk("pc_out", programcounter, m_progc);
        chk("count", {32'b0, fetch_count}, {32'b0, m_count});
        chk("fault", {63'b0, fetch_fault}, 64'h0);
    end

    task automatic cyc(input logic mi, input logic pl, input logic [63:0] np,
                       input logic ack, input logic [31:0] rd, input logic rdy);
        meminit = mi; pc_load = pl; nextpc = np;
        imem_ack = ack; imem_rdata = rd; instr_ready = rdy;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset_n = 0; meminit = 0; pc_load = 0; nextpc = 0;
        imem_ack = 0; imem_rdata = 0; instr_ready = 0;
        @(negedge clock); @(negedge clock);
        chk("rst_req", {63'b0, imem_req}, 64'h0);
        chk("rst_valid", {63'b0, instr_valid}, 64'h0);
        chk("rst_instr", instruction, 64'h0);
        chk("rst_count", {32'b0, fetch_count}, 64'h0);
        reset_n = 1;

        cyc(0, 0, 0, 0, 0, 0);
        chk("first_edge_no_req", {63'b0, imem_req}, 64'h0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("first_req", {63'b0, imem_req}, 64'h1);
        chk("first_addr", imem_addr, 64'h0);
        cyc(0, 0, 0, 1, 32'h8B108493, 0);
        chk("lit_valid", {63'b0, instr_valid}, 64'h1);
        chk("lit_instr", instruction, 64'h0000_0000_8B10_8493);
        chk("lit_f31_21", {53'b0, instr_31_21}, {53'b0, 11'b10001011000});
        chk("lit_f20_16", {59'b0, instr_20_16}, {59'b0, 5'b10000});
        chk("lit_f9_5", {59'b0, instr_9_5}, {59'b0, 5'b00100});
        chk("lit_f4_0", {59'b0, instr_4_0}, {59'b0, 5'b10011});
        chk("lit_pc0", programcounter, 64'h0);

        for (int i = 0; i < 5; i++) cyc(0, 0, 0, (i == 2), 32'hFFFF_FFFF, 0);
        chk("hold_stable", instruction, 64'h0000_0000_8B10_8493);
        chk("hold_noreq", {63'b0, imem_req}, 64'h0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("accept_count", {32'b0, fetch_count}, 64'h1);
        chk("next_addr", imem_addr, 64'h4);

        cyc(0, 0, 0, 1, 32'hD503201F, 0);
        chk("pc4", programcounter, 64'h4);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("addr8", imem_addr, 64'h8);

        cyc(0, 1, 64'h103, 1, 32'h1234_5678, 1);
        chk("redir_valid", {63'b0, instr_valid}, 64'h0);
        chk("redir_idle", {63'b0, imem_req}, 64'h0);
        chk("redir_drop", programcounter, 64'h4);
        cyc(0, 0, 0, 0, 0, 0);
        chk("redir_addr", imem_addr, 64'h100);
        cyc(0, 0, 0, 1, 32'hAABB_CCDD, 0);
        chk("pc100", programcounter, 64'h100);

        cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 1);
        chk("redir_nocount", {32'b0, fetch_count}, 64'h2);
        cyc(0, 0, 0, 0, 0, 0);
        chk("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(0, 0, 0, 1, 32'h1111_2222, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("wrap_addr", imem_addr, 64'h0);
        chk("count3", {32'b0, fetch_count}, 64'h3);

        cyc(0, 0, 0, 1, 32'h3333_4444, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 32'h5555_6666, 0);
        chk("pc_before_init", programcounter, 64'h4);
        cyc(1, 0, 0, 1, 32'h7777_8888, 1);
        chk("init_valid", {63'b0, instr_valid}, 64'h0);
        chk("init_nocount", {32'b0, fetch_count}, 64'h4);
        cyc(1, 1, 64'h500, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("init_addr", imem_addr, RST_PC);
        chk("init_req", {63'b0, imem_req}, 64'h1);
        cyc(0, 0, 0, 1, 32'h9999_AAAA, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("final_addr", imem_addr, RST_PC + 64'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC loaded on reset and on meminit.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, maximum WAIT cycles before fault (only used when IFU_TIMEOUT_EN is defined).
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 meminit  input  1  instruction memory loading; holds fetch off while 1.
REQ-006 pc_load  input  1  redirect strobe; loads nextpc as the fetch address.
REQ-007 nextpc  input  64  redirect target from the CPU.
REQ-008 imem_req  output  1  memory read request, held until imem_ack.
REQ-009 imem_addr  output  64  word-aligned read address, stable while imem_req=1.
REQ-010 imem_ack  input  1  read data valid this cycle.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 instruction  output  64  {32'b0, fetched word}.
REQ-013 instr_31_21 / instr_20_16 / instr_9_5 / instr_4_0  output  11/5/5/5  instruction bit fields.
REQ-014 programcounter  output  64  address of the presented instruction.
REQ-015 instr_valid  output  1  instruction outputs valid.
REQ-016 instr_ready  input  1  CPU accepts; transfer when instr_valid&&instr_ready.
REQ-017 fetch_count  output  32  accepted-transfer counter, wraps at 2^32.
REQ-018 fetch_fault  output  1  sticky memory-timeout flag.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT and HOLD.
- IDLE: imem_req=0; meminit=0 -> WAIT.
- WAIT: imem_req=1, imem_addr=pc_reg; imem_ack -> register imem_rdata into instruction and fields, programcounter<=pc_reg, pc_reg<=pc_reg+4, instr_valid<=1, go HOLD.
- HOLD: outputs held stable; on transfer -> instr_valid<=0, fetch_count+1, go WAIT.
REQ-020 Minimum latency SHALL be 1 cycle from imem_ack to instr_valid=1; at most one instruction outstanding.
REQ-021 Field outputs SHALL equal instruction[31:21], [20:16], [9:5], [4:0] at all times.
REQ-022 PC increment SHALL be modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC+4 -> 64'h0.
REQ-023 pc_load SHALL, in any state, set pc_reg<={nextpc[63:2],2'b00}, clear instr_valid next cycle, and force IDLE for exactly one cycle (imem_req=0) before WAIT resumes with the new address.
REQ-024 pc_load SHALL take priority over imem_ack and instr_ready in the same cycle; that ack's data is discarded and no transfer is counted.
REQ-025 meminit=1 in any state SHALL force IDLE next cycle, clear instr_valid, set pc_reg<=RESET_PC; meminit outranks pc_load.
REQ-026 imem_ack outside WAIT SHALL be ignored.

Reset
REQ-027 reset_n=0 SHALL immediately set state=IDLE, pc_reg=RESET_PC, and imem_req, imem_addr, instruction, all fields, programcounter, instr_valid, fetch_count, fetch_fault to 0.
REQ-028 After reset_n rises, the first imem_req SHALL assert no earlier than the second rising edge with meminit=0.

Configuration
REQ-029 With macro IFU_TIMEOUT_EN defined, an 8-bit counter SHALL count consecutive WAIT cycles; reaching TIMEOUT_CYCLES without imem_ack sets fetch_fault=1, drops imem_req and enters IDLE, remaining there until pc_load (which clears fetch_fault) or reset.
REQ-030 Without IFU_TIMEOUT_EN, fetch_fault SHALL be tied 0 and WAIT SHALL last indefinitely.

Verification
REQ-031 Reset, meminit=0, imem_ack on the first request with rdata=32'h8B108493 -> imem_addr=0; next cycle instr_valid=1, instruction=64'h0000_0000_8B10_8493, instr_31_21=11'b10001011000, instr_20_16=5'b10000, instr_9_5=5'b00100, instr_4_0=5'b10011, programcounter=0.
REQ-032 instr_ready held 0 for 5 cycles in HOLD -> outputs stable, imem_req=0; raise instr_ready -> fetch_count=1, next imem_addr=4.
REQ-033 pc_load with nextpc=64'h103 in the same cycle as imem_ack -> data dropped, instr_valid=0, one idle cycle, then imem_addr=64'h100.
REQ-034 pc_reg=64'hFFFF_FFFF_FFFF_FFFC, ack -> next imem_addr=0.
REQ-035 IFU_TIMEOUT_EN defined, no imem_ack for 255 cycles -> fetch_fault=1, imem_req=0; pc_load -> fetch_fault=0, fetch restarts.
REQ-036 meminit=1 mid-HOLD -> instr_valid=0 next cycle, IDLE; release -> imem_addr=RESET_PC.
